sha3_padder_gen: RTL
====================

// Module: sha3_padder_gen
// PURPOSE
//  Parametrised multi-rate input padder for the Keccak/SHA-3 core.
//  - Packs W-bit message words into one RATE-bit block.
//  - Applies multi-rate padding with a configurable domain-separation byte (SHA3 / Keccak / SHAKE).
//  - Presents each full block to the permutation with a ready/ack handshake.
//  - Sits between the host word interface and the f_permutation stage.
// PARAMETERS
//  W        32    input word width in bits; 32 or 64
//  RATE     576   block (rate) width in bits; multiple of W (576/832/1088/1152)
//  DSBYTE   8'h06 domain byte (8'h06 SHA3, 8'h01 Keccak, 8'h1F SHAKE)
// PORTS
//  clk        in   1          clock, rising edge
//  reset_n    in   1          asynchronous reset, active low
//  clear      in   1          synchronous message restart; same effect as reset
//  in         in   W          message word; first byte in MSBs
//  in_ready   in   1          word valid this cycle
//  is_last    in   1          final word of message; qualified by in_ready
//  byte_num   in   $clog2(W/8) valid bytes in the is_last word (0..W/8-1), MSB-aligned
//  buffer_full out 1          block complete; input not accepted
//  out        out  RATE       padded block; word 0 in out[RATE-1 -: W]
//  out_ready  out  1          out holds a complete block
//  blk_last   out  1          block on out is the final (padded) block; valid with out_ready
//  f_ack      in   1          permutation consumed out
// BEHAVIOUR
//  Reset (reset_n=0, async) or clear: out=0, buffer_full=0, out_ready=0, blk_last=0, word count=0, state ACCEPT.
//  States:
//   - ACCEPT: an in_ready word with is_last=0 is written at slot cnt; cnt++.
//     - cnt reaching RATE/W -> FULL.
//     - in_ready & is_last: keep the top byte_num bytes, write DSBYTE in the next byte, zero the rest of the word.
//       - If this word is slot RATE/W-1, OR 8'h80 into its LSB and go to FULL with blk_last=1.
//       - Otherwise go to PAD.
//   - PAD: one word per cycle. Zero words are written; the final slot is 32'h80 (low byte 8'h80).
//     - After the final slot: FULL with blk_last=1. in_ready is ignored.
//   - FULL: buffer_full=1, out_ready=1, out stable; in_ready ignored (upstream holds its word).
//     - On f_ack: cnt=0, out_ready=0, buffer_full=0 next cycle.
//       - blk_last=0 -> ACCEPT.
//       - blk_last=1 -> DONE.
//   - DONE: all inputs ignored; outputs 0 except out, which is retained. Leave only via clear or reset_n.
//  Latency:
//   - The word completing a block raises out_ready on the next cycle.
//   - An is_last word at slot k raises out_ready (RATE/W-1-k)+1 cycles later.
//  Boundaries:
//   - byte_num=0 with is_last: the word carries no data; it becomes DSBYTE followed by zeros.
//     This is the required encoding for byte-aligned messages.
//   - DSBYTE and 8'h80 in the same byte give DSBYTE|8'h80 (e.g. 8'h86).
//   - Padding never spills into an extra block, because byte_num <= W/8-1.
//   - f_ack outside FULL: ignored.
//   - f_ack and in_ready in the same FULL cycle: the ack is taken and the word is not accepted.
//   - clear has priority over every other input in the same cycle.
//   - reset_n low mid-PAD or mid-FULL: immediate return to reset values.
// STRUCTURE
//  sha3_pkg:
//   - DS_SHA3=8'h06, DS_KECCAK=8'h01, DS_SHAKE=8'h1F.
//   - RATE_224=1152, RATE_256=1088, RATE_384=832, RATE_512=576.
//   - State encoding (ACCEPT, PAD, FULL, DONE).
//  Sub-module sha3_pad_word (combinational):
//   - Inputs: in, byte_num, is_last, final_slot, pad_only.
//   - Output: the W-bit word written to the block.
//  Top level: control FSM, slot counter, and a RATE-bit register written per slot.
// TESTING
//  All scenarios use W=32, RATE=576, DSBYTE=06 unless noted.
//  1. "Hell","o, w","orld", then is_last byte_num=0, in=0:
//     - out[575:480]="Hello, world".
//     - Slot 3 = 32'h06000000, slots 4..16 = 0, slot 17 = 32'h00000080.
//     - out_ready and blk_last=1 are high 15 cycles after the is_last word.
//  2. 17 words, then is_last byte_num=3 "dog ":
//     - Slot 17 = {"dog",8'h86}; FULL on the next cycle; blk_last=1.
//  3. 18 full words, hold a 19th word with f_ack low for 5 cycles, then pulse f_ack, then is_last byte_num=0:
//     - Block 1 has blk_last=0 and out stays stable while stalled.
//     - The held word is not taken before the ack.
//     - Block 2 has slot 0 = the held word, slot 1 = 32'h06000000, slot 17 = 32'h80.
//  4. Parameters W=64, RATE=1088, DSBYTE=1F; "12345678" then is_last byte_num=2 "90":
//     - Slot 1 = 64'h3930_1F00_0000_0000.
//     - Slot 16 = 64'h80; out_ready; blk_last=1.
//  5. reset_n low for 1 cycle mid-PAD (after "Hell" then is_last byte_num=1):
//     - All outputs 0 within the reset cycle.
//     - A repeat of scenario 1 then reproduces scenario 1's block exactly.
//  6. In DONE, apply in_ready and f_ack for 10 cycles, then clear:
//     - No state change during the 10 cycles.
//     - After clear: cnt=0 and state ACCEPT, checked by accepting "Test".

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA-3 input padder.
package sha3_pkg;

   // Domain-separation bytes
   localparam logic [7:0] DS_SHA3   = 8'h06;
   localparam logic [7:0] DS_KECCAK = 8'h01;
   localparam logic [7:0] DS_SHAKE  = 8'h1F;

   // Rate widths in bits for each digest size
   localparam int unsigned RATE_224 = 1152;
   localparam int unsigned RATE_256 = 1088;
   localparam int unsigned RATE_384 = 832;
   localparam int unsigned RATE_512 = 576;

   // Padder control states
   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_PAD    = 2'd1,
      ST_FULL   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/sha3_padder_gen_if.sv
// Word-in / block-out bus between host, padder and permutation stage.
interface sha3_padder_gen_if #(
   parameter int unsigned W    = 32,
   parameter int unsigned RATE = 576
);
   localparam int unsigned BW = $clog2(W/8);

   logic [W-1:0]    in;
   logic            in_ready;
   logic            is_last;
   logic [BW-1:0]   byte_num;
   logic            buffer_full;
   logic [RATE-1:0] out;
   logic            out_ready;
   logic            blk_last;
   logic            f_ack;

   // Host / permutation side
   modport master (
      output in, in_ready, is_last, byte_num, f_ack,
      input  buffer_full, out, out_ready, blk_last
   );

   // Padder side
   modport slave (
      input  in, in_ready, is_last, byte_num, f_ack,
      output buffer_full, out, out_ready, blk_last
   );
endinterface

// File: rtl/sha3_pad_word.sv
// Builds the W-bit word written into the current block slot:
// pass-through data, a truncated final word with the domain byte, or pad fill.
module sha3_pad_word #(
   parameter int unsigned W      = 32,
   parameter logic [7:0]  DSBYTE = 8'h06,
   localparam int unsigned NB    = W/8,
   localparam int unsigned BW    = $clog2(W/8)
) (
   input  logic [W-1:0]  in_i,
   input  logic [BW-1:0] byte_num_i,
   input  logic          is_last_i,
   input  logic          final_slot_i,
   input  logic          pad_only_i,
   output logic [W-1:0]  word_o
);

   // Byte-wise selection of data, domain byte and zero fill; 8'h80 closes the block
   always_comb begin
      word_o = '0;
      if (pad_only_i) begin
         if (final_slot_i) word_o[7:0] = 8'h80;
      end else if (!is_last_i) begin
         word_o = in_i;
      end else begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (BW'(b) < byte_num_i)
               word_o[W-1-8*b -: 8] = in_i[W-1-8*b -: 8];
            else if (BW'(b) == byte_num_i)
               word_o[W-1-8*b -: 8] = DSBYTE;
         end
         if (final_slot_i) word_o[7:0] = word_o[7:0] | 8'h80;
      end
   end

endmodule

// File: rtl/sha3_padder_gen.sv
// SHA-3 multi-rate input padder: packs W-bit words into a RATE-bit block,
// pads the final message block and hands blocks to the permutation.
module sha3_padder_gen
   import sha3_pkg::*;
#(
   parameter int unsigned W      = 32,
   parameter int unsigned RATE   = 576,
   parameter logic [7:0]  DSBYTE = DS_SHA3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   sha3_padder_gen_if.slave bus
);

   localparam int unsigned N  = RATE/W;
   localparam int unsigned CW = $clog2(N+1);

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [RATE-1:0] out_q;
   logic            buffer_full_q;
   logic            out_ready_q;
   logic            blk_last_q;

   logic            final_slot;
   logic            pad_only;
   logic            wr_en;
   logic [W-1:0]    word_d;

   assign final_slot = (cnt_q == CW'(N-1));
   assign pad_only   = (state_q == ST_PAD);
   assign wr_en      = ((state_q == ST_ACCEPT) && bus.in_ready) || (state_q == ST_PAD);

   sha3_pad_word #(
      .W      (W),
      .DSBYTE (DSBYTE)
   ) u_pad_word (
      .in_i         (bus.in),
      .byte_num_i   (bus.byte_num),
      .is_last_i    (bus.is_last),
      .final_slot_i (final_slot),
      .pad_only_i   (pad_only),
      .word_o       (word_d)
   );

   // Control FSM: slot counter, state and registered handshake outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_ACCEPT;
         cnt_q         <= '0;
         buffer_full_q <= 1'b0;
         out_ready_q   <= 1'b0;
         blk_last_q    <= 1'b0;
      end else if (clear) begin
         state_q       <= ST_ACCEPT;
         cnt_q         <= '0;
         buffer_full_q <= 1'b0;
         out_ready_q   <= 1'b0;
         blk_last_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_ACCEPT: begin
               if (bus.in_ready) begin
                  if (bus.is_last) begin
                     if (final_slot) begin
                        state_q       <= ST_FULL;
                        buffer_full_q <= 1'b1;
                        out_ready_q   <= 1'b1;
                        blk_last_q    <= 1'b1;
                     end else begin
                        state_q <= ST_PAD;
                        cnt_q   <= cnt_q + 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                     if (final_slot) begin
                        state_q       <= ST_FULL;
                        buffer_full_q <= 1'b1;
                        out_ready_q   <= 1'b1;
                     end
                  end
               end
            end
            ST_PAD: begin
               if (final_slot) begin
                  state_q       <= ST_FULL;
                  buffer_full_q <= 1'b1;
                  out_ready_q   <= 1'b1;
                  blk_last_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_FULL: begin
               if (bus.f_ack) begin
                  state_q       <= blk_last_q ? ST_DONE : ST_ACCEPT;
                  cnt_q         <= '0;
                  buffer_full_q <= 1'b0;
                  out_ready_q   <= 1'b0;
                  blk_last_q    <= 1'b0;
               end
            end
            ST_DONE: begin
            end
            default: state_q <= ST_ACCEPT;
         endcase
      end
   end

   // Block register: one W-bit slot written per accepted or pad cycle, word 0 at the top
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q <= '0;
      end else if (clear) begin
         out_q <= '0;
      end else if (wr_en) begin
         for (int unsigned s = 0; s < N; s++) begin
            if (cnt_q == CW'(s)) out_q[RATE-1-W*s -: W] <= word_d;
         end
      end
   end

   assign bus.out         = out_q;
   assign bus.out_ready   = out_ready_q;
   assign bus.buffer_full = buffer_full_q;
   assign bus.blk_last    = blk_last_q;

endmodule
